// File: rtl/sha512_arbiter_if.sv
// Requester-side bundle for sha512_arbiter. There is one instance per requester.
// Signal suffixes are from the arbiter's point of view.
interface sha512_arbiter_if;
    logic        valid_i;   // block word valid
    logic        ready_o;   // block word accepted
    logic [31:0] data_i;    // block word, MSW first
    logic        first_i;   // first block of a message, sampled with word 0
    logic        last_i;    // final block of a message, sampled with the last word
    logic        dvalid_o;  // digest word valid
    logic        dready_i;  // digest word consumed
    logic [31:0] digest_o;  // digest word, MSW first

    // Requester side
    modport master (
        output valid_i, data_i, first_i, last_i, dready_i,
        input  ready_o, dvalid_o, digest_o
    );

    // Arbiter side
    modport slave (
        input  valid_i, data_i, first_i, last_i, dready_i,
        output ready_o, dvalid_o, digest_o
    );
endinterface

// File: rtl/sha512_arbiter.sv
// sha512_arbiter: shares one sha512 core between two requesters.
// A 1024-bit block is buffered from the granted requester, then the core receives
// START/CONT and a 32-word burst. After the last block, the 16-word digest is read
// back and handed to the owner. The grant is held for the whole message.
module sha512_arbiter #(
    parameter int unsigned BLOCK_WORDS  = 32,
    parameter int unsigned DIGEST_WORDS = 16,
    parameter logic [3:0]  CMD_START    = 4'h1,
    parameter logic [3:0]  CMD_CONT     = 4'h2,
    parameter logic [3:0]  CMD_READ     = 4'h3,
    parameter int unsigned BUSY_BIT     = 4,
    parameter int unsigned READ_LAT     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    sha512_arbiter_if.slave        req0,
    sha512_arbiter_if.slave        req1,
    output logic [31:0]            core_text_o,
    input  logic [31:0]            core_text_i,
    output logic [3:0]             core_cmd_o,
    output logic                   core_cmd_w_o,
    input  logic [4:0]             core_status_i,
    output logic                   grant_o,
    output logic                   busy_o
);

    localparam int unsigned WW = $clog2(BLOCK_WORDS);
    localparam int unsigned DW = $clog2(DIGEST_WORDS);
    localparam int unsigned LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    localparam logic [WW-1:0] W_LAST   = WW'(BLOCK_WORDS - 1);
    localparam logic [DW-1:0] D_LAST   = DW'(DIGEST_WORDS - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(READ_LAT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CMD   = 3'd2;
    localparam logic [2:0] S_PUSH  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_RDCMD = 3'd5;
    localparam logic [2:0] S_RDCAP = 3'd6;
    localparam logic [2:0] S_DOUT  = 3'd7;

    logic [2:0]    r_state;
    logic          r_grant;
    logic          r_prio;
    logic [31:0]   r_buf [BLOCK_WORDS];
    logic [31:0]   r_dig [DIGEST_WORDS];
    logic [WW-1:0] r_wcnt;
    logic [DW-1:0] r_dcnt;
    logic [LW-1:0] r_lat;
    logic          r_first;
    logic          r_last;
    logic          r_wfirst;

    logic          w_v0;
    logic          w_v1;
    logic          w_win;
    logic          w_load;
    logic          w_dout;
    logic          w_sel_valid;
    logic [31:0]   w_sel_data;
    logic          w_sel_first;
    logic          w_sel_last;
    logic          w_sel_dready;
    logic          w_xfer;
    logic          w_dxfer;
    logic          w_core_busy;
    logic [31:0]   w_digest;
    logic          w_status_unused;

    // Request selection. The priority pointer breaks ties, and the owner's signals are muxed.
    always_comb begin
        w_v0         = req0.valid_i;
        w_v1         = req1.valid_i;
        w_win        = (w_v0 && w_v1) ? r_prio : w_v1;
        w_load       = (r_state == S_LOAD);
        w_dout       = (r_state == S_DOUT);
        w_sel_valid  = r_grant ? req1.valid_i  : req0.valid_i;
        w_sel_data   = r_grant ? req1.data_i   : req0.data_i;
        w_sel_first  = r_grant ? req1.first_i  : req0.first_i;
        w_sel_last   = r_grant ? req1.last_i   : req0.last_i;
        w_sel_dready = r_grant ? req1.dready_i : req0.dready_i;
        w_xfer       = w_load && w_sel_valid;
        w_dxfer      = w_dout && w_sel_dready;
        w_core_busy  = core_status_i[BUSY_BIT];
        w_digest     = r_dig[r_dcnt];
    end

    // Only the busy flag of the core status is meaningful here
    assign w_status_unused = ^core_status_i;

    // Requester-facing handshakes. Only the owner ever sees ready/dvalid.
    always_comb begin
        req0.ready_o  = w_load && !r_grant;
        req1.ready_o  = w_load &&  r_grant;
        req0.dvalid_o = w_dout && !r_grant;
        req1.dvalid_o = w_dout &&  r_grant;
        req0.digest_o = (w_dout && !r_grant) ? w_digest : '0;
        req1.digest_o = (w_dout &&  r_grant) ? w_digest : '0;
    end

    // Core-facing command and text bus. All of it is quiet except in CMD, RDCMD and PUSH.
    always_comb begin
        core_cmd_w_o = 1'b0;
        core_cmd_o   = '0;
        core_text_o  = '0;
        case (r_state)
            S_CMD: begin
                core_cmd_w_o = 1'b1;
                core_cmd_o   = r_first ? CMD_START : CMD_CONT;
            end
            S_RDCMD: begin
                core_cmd_w_o = 1'b1;
                core_cmd_o   = CMD_READ;
            end
            S_PUSH: core_text_o = r_buf[r_wcnt];
            default: ;
        endcase
        grant_o = r_grant;
        busy_o  = (r_state != S_IDLE);
    end

    // Arbitration, block buffering, core sequencing and digest delivery
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_grant  <= 1'b0;
            r_prio   <= 1'b0;
            r_wcnt   <= '0;
            r_dcnt   <= '0;
            r_lat    <= '0;
            r_first  <= 1'b0;
            r_last   <= 1'b0;
            r_wfirst <= 1'b0;
            for (int unsigned i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
            for (int unsigned i = 0; i < DIGEST_WORDS; i++) r_dig[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_v0 || w_v1) begin
                        r_grant <= w_win;
                        r_wcnt  <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_buf[r_wcnt] <= w_sel_data;
                        if (r_wcnt == '0) r_first <= w_sel_first;
                        if (r_wcnt == W_LAST) begin
                            r_last  <= w_sel_last;
                            r_wcnt  <= '0;
                            r_state <= S_CMD;
                        end else begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                    end
                end
                S_CMD: begin
                    r_state <= S_PUSH;
                end
                S_PUSH: begin
                    if (r_wcnt == W_LAST) begin
                        r_wcnt   <= '0;
                        r_wfirst <= 1'b1;
                        r_state  <= S_WAIT;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // The core may not have raised busy yet on the first cycle
                    if (r_wfirst) begin
                        r_wfirst <= 1'b0;
                    end else if (!w_core_busy) begin
                        r_state <= r_last ? S_RDCMD : S_LOAD;
                    end
                end
                S_RDCMD: begin
                    r_lat   <= LAT_INIT;
                    r_dcnt  <= '0;
                    r_state <= S_RDCAP;
                end
                S_RDCAP: begin
                    if (r_lat != '0) begin
                        r_lat <= r_lat - 1'b1;
                    end else begin
                        r_dig[r_dcnt] <= core_text_i;
                        if (r_dcnt == D_LAST) begin
                            r_dcnt  <= '0;
                            r_state <= S_DOUT;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                end
                S_DOUT: begin
                    if (w_dxfer) begin
                        if (r_dcnt == D_LAST) begin
                            r_dcnt  <= '0;
                            r_prio  <= ~r_grant;
                            r_state <= S_IDLE;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha512_arbiter.sv
// Directed testbench for sha512_arbiter with a behavioural stand-in for the sha512 core.
// The stand-in logs commands and pushed words, stays busy for a fixed time, and returns
// a digest derived from the sum of the pushed words and the number of blocks.
`timescale 1ns/1ps
module tb_sha512_arbiter;

    localparam logic [3:0] CMD_START = 4'h1;
    localparam logic [3:0] CMD_CONT  = 4'h2;
    localparam logic [3:0] CMD_READ  = 4'h3;
    localparam int BUSY_CYC = 80;
    localparam int TMO      = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] core_text_o;
    logic [31:0] core_text_i;
    logic [3:0]  core_cmd;
    logic        core_cmd_w;
    logic [4:0]  core_status;
    logic        grant;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sha512_arbiter_if r0_if ();
    sha512_arbiter_if r1_if ();

    sha512_arbiter #(
        .BLOCK_WORDS(32), .DIGEST_WORDS(16), .CMD_START(CMD_START), .CMD_CONT(CMD_CONT),
        .CMD_READ(CMD_READ), .BUSY_BIT(4), .READ_LAT(1)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .req0(r0_if), .req1(r1_if),
        .core_text_o(core_text_o), .core_text_i(core_text_i), .core_cmd_o(core_cmd),
        .core_cmd_w_o(core_cmd_w), .core_status_i(core_status), .grant_o(grant), .busy_o(busy)
    );

    function automatic logic [31:0] exp_dig(input logic [31:0] sum, input int blocks, input int k);
        return sum + 32'(k) * 32'h11111111 + (32'(blocks) << 24);
    endfunction

    function automatic logic [31:0] sum_block(input logic [31:0] base);
        logic [31:0] s = '0;
        for (int i = 0; i < 32; i++) s = s + base + 32'(i);
        return s;
    endfunction

    // ---------------- core stand-in ----------------
    int          busy_cnt, push_cnt, rd_cnt, blk_cnt, stray;
    logic [31:0] acc;
    logic [3:0]  cmd_log [$];
    logic [31:0] push_log [$];

    assign core_status = {busy_cnt != 0, 4'b0000};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            busy_cnt <= 0; push_cnt <= 0; rd_cnt <= 0; blk_cnt <= 0; acc <= '0;
            core_text_i <= '0;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (push_cnt != 0) begin
                push_log.push_back(core_text_o);
                acc <= acc + core_text_o;
                push_cnt <= push_cnt - 1;
                if (push_cnt == 1) blk_cnt <= blk_cnt + 1;
            end else if (core_text_o != '0) begin
                stray <= stray + 1;
            end
            if (core_cmd_w) begin
                cmd_log.push_back(core_cmd);
                if (core_cmd == CMD_START || core_cmd == CMD_CONT) begin
                    push_cnt <= 32;
                    busy_cnt <= 32 + BUSY_CYC;
                    if (core_cmd == CMD_START) begin acc <= '0; blk_cnt <= 0; end
                end
            end
            if (core_cmd_w && core_cmd == CMD_READ) begin
                core_text_i <= exp_dig(acc, blk_cnt, 0);
                rd_cnt <= 1;
            end else if (rd_cnt != 0 && rd_cnt < 16) begin
                core_text_i <= exp_dig(acc, blk_cnt, rd_cnt);
                rd_cnt <= rd_cnt + 1;
            end else begin
                core_text_i <= '0;
                rd_cnt <= 0;
            end
        end
    end

    // ---------------- requester monitors ----------------
    int r0_ready_cnt, r1_ready_cnt;
    always @(negedge clk) begin
        if (r0_if.ready_o) r0_ready_cnt <= r0_ready_cnt + 1;
        if (r1_if.ready_o) r1_ready_cnt <= r1_ready_cnt + 1;
    end

    logic [31:0] rx [2][16];
    int          done_cyc [2];
    bit          stall_rdy;
    int          stall_cmds;

    task automatic clear_logs();
        cmd_log.delete(); push_log.delete();
        stray = 0; r0_ready_cnt = 0; r1_ready_cnt = 0;
    endtask

    task automatic set_req(input int port, input logic v, input logic [31:0] d, input logic f, input logic l);
        if (port == 0) begin
            r0_if.valid_i = v; r0_if.data_i = d; r0_if.first_i = f; r0_if.last_i = l;
        end else begin
            r1_if.valid_i = v; r1_if.data_i = d; r1_if.first_i = f; r1_if.last_i = l;
        end
    endtask

    function automatic logic get_ready(input int port);
        return (port == 0) ? r0_if.ready_o : r1_if.ready_o;
    endfunction

    // Drives one block (word i = base+i). Optionally drops valid for stall_len cycles before word stall_at.
    task automatic send_block(input int port, input logic [31:0] base, input logic first, input logic last,
                              input int stall_at, input int stall_len, output bit ok);
        int i = 0;
        int tmo = 0;
        bit stalled = 0;
        ok = 1;
        while (i < 32 && ok) begin
            @(negedge clk);
            if (i == stall_at && !stalled) begin
                stalled = 1;
                set_req(port, 1'b0, '0, 1'b0, 1'b0);
                stall_rdy = 1'b1;
                #1;
                if (!get_ready(port)) stall_rdy = 1'b0;
                repeat (stall_len - 1) begin
                    @(negedge clk); #1;
                    if (!get_ready(port)) stall_rdy = 1'b0;
                end
                stall_cmds = cmd_log.size();
            end else begin
                set_req(port, 1'b1, base + 32'(i), (i == 0) ? first : 1'b0, (i == 31) ? last : 1'b0);
                #1;
                if (get_ready(port)) i++;
                else begin tmo++; if (tmo > TMO) ok = 0; end
            end
        end
        @(negedge clk);
        set_req(port, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic recv_digest(input int port, output bit ok);
        int k = 0;
        int tmo = 0;
        ok = 1;
        if (port == 0) r0_if.dready_i = 1'b1; else r1_if.dready_i = 1'b1;
        while (k < 16 && ok) begin
            @(negedge clk); #1;
            if (port == 0 && r0_if.dvalid_o) begin rx[0][k] = r0_if.digest_o; k++; end
            else if (port == 1 && r1_if.dvalid_o) begin rx[1][k] = r1_if.digest_o; k++; end
            else begin tmo++; if (tmo > TMO) ok = 0; end
        end
        done_cyc[port] = cyc;
        @(negedge clk);
        if (port == 0) r0_if.dready_i = 1'b0; else r1_if.dready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({r0_if.ready_o, r0_if.dvalid_o, r0_if.digest_o, r1_if.ready_o, r1_if.dvalid_o, r1_if.digest_o,
             core_text_o, core_cmd, core_cmd_w, grant, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got r0rdy=%b r1rdy=%b text=%h cmd=%h cmdw=%b grant=%b busy=%b required all 0",
                     r0_if.ready_o, r1_if.ready_o, core_text_o, core_cmd, core_cmd_w, grant, busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_after_reset: busy=%b required 0", busy); end
    endtask

    task automatic test_single_block();
        bit ok;
        logic [31:0] sum;
        int bad = 0;
        clear_logs();
        send_block(0, 32'h0, 1'b1, 1'b1, -1, 0, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL single_send: timeout"); end
        checks++;
        if (grant !== 1'b0) begin failures++; $display("FAIL single_grant: got %b required 0", grant); end
        recv_digest(0, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL single_recv: timeout"); end
        checks++;
        if (cmd_log.size() != 2 || cmd_log[0] !== CMD_START || cmd_log[1] !== CMD_READ) begin
            failures++; $display("FAIL single_cmds: got n=%0d required START,READ", cmd_log.size());
        end
        for (int i = 0; i < 32; i++) if (i >= push_log.size() || push_log[i] !== 32'(i)) bad++;
        checks++;
        if (bad != 0 || push_log.size() != 32) begin
            failures++; $display("FAIL single_push: got %0d words, %0d wrong, required 32 words 0..31", push_log.size(), bad);
        end
        sum = sum_block(32'h0);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (rx[0][k] !== exp_dig(sum, 1, k)) begin
                failures++; $display("FAIL single_digest[%0d]: got %h required %h", k, rx[0][k], exp_dig(sum, 1, k));
            end
        end
        checks++;
        if (r1_ready_cnt != 0) begin failures++; $display("FAIL single_req1_ready: got %0d cycles high required 0", r1_ready_cnt); end
        checks++;
        if (stray != 0) begin failures++; $display("FAIL single_text_quiet: got %0d stray cycles required 0", stray); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_arbitration();
        bit ok0, ok1, s0, s1;
        logic [31:0] bases [4];
        bases[0] = 32'h100; bases[1] = 32'h200; bases[2] = 32'h300; bases[3] = 32'h400;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int round = 0; round < 2; round++) begin
            clear_logs();
            fork
                begin send_block(0, bases[2*round], 1'b1, 1'b1, -1, 0, s0); recv_digest(0, ok0); end
                begin send_block(1, bases[2*round+1], 1'b1, 1'b1, -1, 0, s1); recv_digest(1, ok1); end
            join
            checks++;
            if ({s0, s1, ok0, ok1} !== 4'b1111) begin failures++; $display("FAIL arb%0d_handshake: got %b required 1111", round, {s0, s1, ok0, ok1}); end
            checks++;
            if (!(done_cyc[0] < done_cyc[1])) begin
                failures++; $display("FAIL arb%0d_order: port0 done %0d port1 done %0d required port0 first", round, done_cyc[0], done_cyc[1]);
            end
            checks++;
            if (push_log.size() != 64 || push_log[0] !== bases[2*round] || push_log[32] !== bases[2*round+1]) begin
                failures++; $display("FAIL arb%0d_push_order: got n=%0d required 64 with port0 block first", round, push_log.size());
            end
            checks++;
            if (rx[0][0] !== exp_dig(sum_block(bases[2*round]), 1, 0)) begin
                failures++; $display("FAIL arb%0d_digest0: got %h required %h", round, rx[0][0], exp_dig(sum_block(bases[2*round]), 1, 0));
            end
            checks++;
            if (rx[1][15] !== exp_dig(sum_block(bases[2*round+1]), 1, 15)) begin
                failures++; $display("FAIL arb%0d_digest1: got %h required %h", round, rx[1][15], exp_dig(sum_block(bases[2*round+1]), 1, 15));
            end
            checks++;
            if (grant !== 1'b1 || busy !== 1'b0) begin
                failures++; $display("FAIL arb%0d_idle_grant: got grant=%b busy=%b required 1 0", round, grant, busy);
            end
        end
    endtask

    task automatic test_multi_block();
        bit ok, okr;
        logic [31:0] sum;
        int quiet = 0;
        clear_logs();
        send_block(1, 32'h1000, 1'b1, 1'b0, -1, 0, ok);
        if (ok) send_block(1, 32'h2000, 1'b0, 1'b0, -1, 0, ok);
        if (ok) send_block(1, 32'h3000, 1'b0, 1'b1, -1, 0, ok);
        recv_digest(1, okr);
        checks++;
        if ({ok, okr} !== 2'b11) begin failures++; $display("FAIL multi_handshake: got %b required 11", {ok, okr}); end
        checks++;
        if (cmd_log.size() != 4 || cmd_log[0] !== CMD_START || cmd_log[1] !== CMD_CONT ||
            cmd_log[2] !== CMD_CONT || cmd_log[3] !== CMD_READ) begin
            failures++; $display("FAIL multi_cmds: got n=%0d required START,CONT,CONT,READ", cmd_log.size());
        end
        checks++;
        if (push_log.size() != 96) begin failures++; $display("FAIL multi_push_count: got %0d required 96", push_log.size()); end
        sum = sum_block(32'h1000) + sum_block(32'h2000) + sum_block(32'h3000);
        for (int k = 0; k < 16; k += 5) begin
            checks++;
            if (rx[1][k] !== exp_dig(sum, 3, k)) begin
                failures++; $display("FAIL multi_digest[%0d]: got %h required %h", k, rx[1][k], exp_dig(sum, 3, k));
            end
        end
        repeat (50) begin @(negedge clk); if (r1_if.dvalid_o || busy) quiet++; end
        checks++;
        if (quiet != 0) begin failures++; $display("FAIL multi_one_digest: got %0d extra active cycles required 0", quiet); end
        checks++;
        if (r0_ready_cnt != 0) begin failures++; $display("FAIL multi_req0_ready: got %0d required 0", r0_ready_cnt); end
    endtask

    task automatic test_stall();
        bit ok, okr;
        int bad = 0;
        clear_logs();
        send_block(0, 32'h5000, 1'b1, 1'b1, 17, 5, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL stall_send: timeout"); end
        checks++;
        if (stall_rdy !== 1'b1) begin failures++; $display("FAIL stall_ready_held: got %b required 1", stall_rdy); end
        checks++;
        if (stall_cmds != 0) begin failures++; $display("FAIL stall_no_early_cmd: got %0d cmds required 0", stall_cmds); end
        recv_digest(0, okr);
        for (int i = 0; i < 32; i++) if (i >= push_log.size() || push_log[i] !== 32'h5000 + 32'(i)) bad++;
        checks++;
        if (bad != 0 || push_log.size() != 32) begin
            failures++; $display("FAIL stall_push: got %0d words %0d wrong required 32 in order", push_log.size(), bad);
        end
        checks++;
        if (okr !== 1'b1 || rx[0][7] !== exp_dig(sum_block(32'h5000), 1, 7)) begin
            failures++; $display("FAIL stall_digest: got %h required %h", rx[0][7], exp_dig(sum_block(32'h5000), 1, 7));
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit held = 0;
        int k = 0;
        int tmo = 0;
        logic [31:0] sum, got [16];
        clear_logs();
        send_block(0, 32'h7000, 1'b1, 1'b1, -1, 0, ok);
        sum = sum_block(32'h7000);
        r0_if.dready_i = 1'b1;
        while (k < 16 && tmo < TMO) begin
            @(negedge clk); #1;
            if (r0_if.dvalid_o) begin
                if (k == 3 && !held) begin
                    held = 1;
                    r0_if.dready_i = 1'b0;
                    repeat (10) begin
                        @(negedge clk); #1;
                        checks++;
                        if (r0_if.dvalid_o !== 1'b1 || r0_if.digest_o !== exp_dig(sum, 1, 3) || busy !== 1'b1) begin
                            failures++;
                            $display("FAIL bp_hold: got dvalid=%b word=%h busy=%b required 1 %h 1",
                                     r0_if.dvalid_o, r0_if.digest_o, busy, exp_dig(sum, 1, 3));
                        end
                    end
                    r0_if.dready_i = 1'b1;
                end
                if (k == 15) begin
                    checks++;
                    if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy_last: got %b required 1", busy); end
                end
                got[k] = r0_if.digest_o;
                k++;
            end else tmo++;
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || r0_if.dvalid_o !== 1'b0 || k != 16) begin
            failures++; $display("FAIL bp_done: got busy=%b dvalid=%b words=%0d required 0 0 16", busy, r0_if.dvalid_o, k);
        end
        r0_if.dready_i = 1'b0;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (got[j] !== exp_dig(sum, 1, j)) begin
                failures++; $display("FAIL bp_word[%0d]: got %h required %h", j, got[j], exp_dig(sum, 1, j));
            end
        end
    endtask

    task automatic test_reset_mid_push();
        bit ok, okr;
        int tmo = 0;
        clear_logs();
        send_block(0, 32'h9000, 1'b1, 1'b1, -1, 0, ok);
        while (cmd_log.size() == 0 && tmo < TMO) begin @(negedge clk); tmo++; end
        checks++;
        if (ok !== 1'b1 || cmd_log.size() != 1) begin failures++; $display("FAIL rstpush_setup: got n=%0d required 1", cmd_log.size()); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({r0_if.ready_o, r0_if.dvalid_o, r0_if.digest_o, r1_if.ready_o, r1_if.dvalid_o, r1_if.digest_o,
             core_text_o, core_cmd, core_cmd_w, grant, busy} !== '0) begin
            failures++;
            $display("FAIL rstpush_outputs: got text=%h cmdw=%b grant=%b busy=%b required all 0", core_text_o, core_cmd_w, grant, busy);
        end
        repeat (150) @(negedge clk);
        checks++;
        if (cmd_log.size() != 1 || push_log.size() >= 32) begin
            failures++; $display("FAIL rstpush_abandon: got cmds=%0d pushes=%0d required 1 and <32", cmd_log.size(), push_log.size());
        end
        clear_logs();
        send_block(1, 32'hA000, 1'b1, 1'b1, -1, 0, ok);
        recv_digest(1, okr);
        checks++;
        if ({ok, okr} !== 2'b11 || cmd_log.size() != 2 || cmd_log[0] !== CMD_START || cmd_log[1] !== CMD_READ) begin
            failures++; $display("FAIL rstpush_next_cmds: got ok=%b n=%0d required 11 START,READ", {ok, okr}, cmd_log.size());
        end
        checks++;
        if (rx[1][9] !== exp_dig(sum_block(32'hA000), 1, 9)) begin
            failures++; $display("FAIL rstpush_next_digest: got %h required %h", rx[1][9], exp_dig(sum_block(32'hA000), 1, 9));
        end
    endtask

    initial begin
        set_req(0, 1'b0, '0, 1'b0, 1'b0);
        set_req(1, 1'b0, '0, 1'b0, 1'b0);
        r0_if.dready_i = 1'b0;
        r1_if.dready_i = 1'b0;
        stray = 0;
        test_reset();
        test_single_block();
        test_arbitration();
        test_multi_block();
        test_stall();
        test_backpressure();
        test_reset_mid_push();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sha512_arbiter.md
Name: sha512_arbiter

Overview:
- Shares one sha512 core between two requesters (port 0, port 1).
- Each requester streams 1024-bit message blocks as 32-bit words and receives the 512-bit digest as 16 words.
- The block buffers each block and issues the core's start/continue/read commands. It bursts data into the core's text input and captures the digest from its text output.
- Sits between requester fabric and the core's text_i/text_o/cmd_i/cmd_w_i/cmd_o pins.

Parameters:
- BLOCK_WORDS, 32, words per message block.
- DIGEST_WORDS, 16, words per digest.
- CMD_START, 4'h1, core command for the first block of a message.
- CMD_CONT, 4'h2, core command for subsequent blocks.
- CMD_READ, 4'h3, core command to read out the digest.
- BUSY_BIT, 4, index of the busy flag in core status.
- READ_LAT, 1, cycles from the CMD_READ write to the first valid digest word.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- reqN_valid_i  in  1  word valid, N=0,1
- reqN_ready_o  out  1  word accepted
- reqN_data_i  in  32  block word, MSW first
- reqN_first_i  in  1  block is the first of a message; sampled with word 0
- reqN_last_i  in  1  block is the final block of a message; sampled with word BLOCK_WORDS-1
- reqN_dvalid_o  out  1  digest word valid
- reqN_dready_i  in  1  digest word consumed
- reqN_digest_o  out  32  digest word, MSW first
- core_text_o  out  32  to core text_i
- core_text_i  in  32  from core text_o
- core_cmd_o  out  4  to core cmd_i
- core_cmd_w_o  out  1  to core cmd_w_i
- core_status_i  in  5  from core cmd_o
- grant_o  out  1  current owner: 0 or 1
- busy_o  out  1  arbiter not IDLE

Behaviour:
- Reset (rst_i=0 at a clk_i edge):
  - State becomes IDLE.
  - All outputs are 0.
  - Priority pointer is 0.
  - Buffers and counters are cleared.
  - Reset mid-operation abandons the message. No further core commands are issued. The core must be reset by the same rst_i.
- Handshakes:
  - A word transfers when valid&&ready.
  - dvalid stays high, with stable data, until dready is sampled high.
- Arbitration:
  - Occurs in IDLE only.
  - Eligible requester: reqN_valid_i=1.
  - If both are eligible, the one matching the priority pointer wins. The pointer flips to the loser after each completed message (digest fully delivered).
  - The grant is held across all blocks of a message until the digest is delivered. The other requester's ready stays 0 throughout.
- IDLE: on a grant, go to LOAD.
- LOAD:
  - reqN_ready_o=1 while the buffer is not full.
  - Store 32 words and count 0..31.
  - Latch the first flag at word 0 and the last flag at word 31.
  - A stalled valid leaves the count unchanged (no timeout).
  - After word 31, go to CMD.
- CMD:
  - One cycle with core_cmd_w_o=1.
  - core_cmd_o=CMD_START if the first flag is set, else CMD_CONT.
  - Go to PUSH.
- PUSH:
  - Exactly 32 consecutive cycles, core_text_o=buf[0..31], one word per cycle, no gaps.
  - Then go to WAIT.
- WAIT:
  - Ignore status for the first cycle.
  - Then stay until core_status_i[BUSY_BIT]=0.
  - On exit: if last is set, go to RDCMD; else go to LOAD for the next block of the same message.
- RDCMD: one cycle with core_cmd_w_o=1, core_cmd_o=CMD_READ. Go to RDCAP.
- RDCAP:
  - After READ_LAT cycles, capture core_text_i on 16 consecutive cycles into the digest buffer.
  - Go to DOUT.
- DOUT:
  - Present digest words 0..15 on the granted port.
  - After the transfer of word 15: dvalid=0, flip the priority pointer, go to IDLE.
  - No new arbitration happens in the same cycle.
- Core-side outputs:
  - core_cmd_w_o is 1 only in CMD and RDCMD.
  - core_text_o is 0 outside PUSH.
- Flag handling:
  - first and last may both be set (single-block message).
  - If the first flag is not set on the first block after a grant, the arbiter still issues CMD_CONT (requester error, not corrected).
- busy_o=1 in every state except IDLE. grant_o holds its last value in IDLE.

Test Plan:
- Single-block message on port 0 with first=last=1, words 0x00000000..0x0000001F, core model busy for 80 cycles:
  - one CMD_START, then 32 pushed words in order, then CMD_READ;
  - 16 digest words delivered on req0 in order;
  - req1_ready_o=0 throughout.
- Both valid in the same cycle after reset: port 0 is served first, then port 1. Repeat with both valid again: port 0 wins, the pointer having returned to 0 after port 1's message.
- Three-block message on port 1 (first on block 0, last on block 2):
  - command sequence START, CONT, CONT, READ;
  - exactly one digest.
- Requester drops valid for 5 cycles at word 17: count holds at 17, no CMD issued early, PUSH still emits 32 contiguous words.
- Digest backpressure: dready low for 10 cycles at word 3 → word 3 held stable, no words lost or duplicated, busy_o stays 1 until word 15 is transferred.
- rst_i=0 for 1 cycle during PUSH → the next cycle has all outputs 0 and state IDLE; a subsequent new message completes normally.
